// File: rtl/cdm_div_pkg.sv
// Shared constants and FSM state type for the cdm_div32_16 restoring divider.
package cdm_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int LANE_W     = 8;
    localparam int PR_W       = 17;
    localparam int CNT_W      = 5;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/cdm_lane_sub.sv
// Two-lane trial subtractor for the divider partial remainder.
// With CDM_DIV_CARRY_DISREGARD_EN defined the borrow out of the low lane is
// dropped (carry-disregard approximation); otherwise the borrow is chained
// and the result is an exact W-bit difference.
module cdm_lane_sub #(
    parameter int W      = 17,
    parameter int LANE_W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff
);

    localparam int HW = W - LANE_W;

    logic [LANE_W-1:0] lo;
    logic [HW-1:0]     hi;

`ifdef CDM_DIV_CARRY_DISREGARD_EN
    assign lo = a[LANE_W-1:0] - b[LANE_W-1:0];
    assign hi = a[W-1:LANE_W] - b[W-1:LANE_W];
`else
    logic borrow;
    assign {borrow, lo} = {1'b0, a[LANE_W-1:0]} - {1'b0, b[LANE_W-1:0]};
    assign hi = a[W-1:LANE_W] - b[W-1:LANE_W] - {{(HW-1){1'b0}}, borrow};
`endif

    assign diff = {hi, lo};

endmodule

// File: rtl/cdm_div32_16.sv
// Sequential radix-2 restoring divider, 32-bit dividend / 16-bit divisor.
// One quotient bit per cycle, 33 cycles accept-to-valid; zero divisor
// short-circuits to DONE in one cycle with div_by_zero set.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its data while valid is high and ready is low.
// Optional macro CDM_DIV_CARRY_DISREGARD_EN selects the lane-split subtractor.
module cdm_div32_16
    import cdm_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    div_state_t            state, state_next;
    logic [PR_W-1:0]       pr;
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic [CNT_W-1:0]      cnt;

    logic [PR_W-1:0]       pr_shift;
    logic [PR_W-1:0]       pr_diff;
    logic [PR_W-1:0]       pr_next;
    logic [DIVIDEND_W-1:0] q_next;
    logic                  ge;
    logic                  pr_msb_unused;

    // Bit 16 of the partial remainder shifts out every iteration.
    assign pr_msb_unused = pr[PR_W-1];

    // One iteration step: shift in next dividend bit, exact compare, subtract.
    assign pr_shift = {pr[PR_W-2:0], q[DIVIDEND_W-1]};
    assign ge       = (pr_shift >= {1'b0, divisor_r});
    assign pr_next  = ge ? pr_diff : pr_shift;
    assign q_next   = {q[DIVIDEND_W-2:0], ge};

    cdm_lane_sub #(
        .W      (PR_W),
        .LANE_W (LANE_W)
    ) u_lane_sub (
        .a    (pr_shift),
        .b    ({1'b0, divisor_r}),
        .diff (pr_diff)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == '0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, iteration, and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr          <= '0;
            q           <= '0;
            divisor_r   <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_r <= divisor;
                        if (divisor == '0) begin
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            pr          <= '0;
                            q           <= dividend;
                            cnt         <= CNT_LAST;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    q   <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= pr_next[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdm_div32_16.sv
// Directed-vector bench for cdm_div32_16: table of operations with
// hand-computed results, plus backpressure and mid-run reset sequences.
module tb_cdm_div32_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    // clock / reset
    always #5 clk = ~clk;

    cdm_div32_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one operation; returns once the accept edge has passed (#1 after).
    task automatic send(input logic [31:0] a, input logic [15:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    // Count cycles from accept until out_valid; lat=1 means first cycle after accept.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: timeout after %0d cycles", lat);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_handoff", {31'b0, out_valid}, 32'd0);
        chk("in_ready_after_handoff", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        logic [31:0] e;
        exp_q.push_back(v.q);
        send(v.a, v.b);
        wait_valid(lat);
        e = exp_q.pop_front();
        chk("latency", lat, v.lat);
        chk("quotient", quotient, e);
        chk("remainder", {16'b0, remainder}, {16'b0, v.r});
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, v.dbz});
        handoff();
        chk("quotient_held", quotient, e);
    endtask

    initial begin
        int lat;
        vecs[0] = '{32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0, 33};
        vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 33};
        vecs[2] = '{32'h1234_5678, 16'h0001, 32'h1234_5678, 16'h0000, 1'b0, 33};
        vecs[3] = '{32'hDEAD_BEEF, 16'h0000, 32'hFFFF_FFFF, 16'hBEEF, 1'b1, 1};
`ifdef CDM_DIV_CARRY_DISREGARD_EN
        vecs[4] = '{32'h0000_0200, 16'h0105, 32'h0000_0001, 16'h01FB, 1'b0, 33};
`else
        vecs[4] = '{32'h0000_0200, 16'h0105, 32'h0000_0001, 16'h00FB, 1'b0, 33};
`endif
        vecs[5] = '{32'h0000_0000, 16'h0005, 32'h0000_0000, 16'h0000, 1'b0, 33};
        vecs[6] = '{32'h0000_1000, 16'h0010, 32'h0000_0100, 16'h0000, 1'b0, 33};
        vecs[7] = '{32'h8000_0000, 16'h0003, 32'h2AAA_AAAA, 16'h0002, 1'b0, 33};
        vecs[8] = '{32'h0000_0005, 16'h0009, 32'h0000_0000, 16'h0005, 1'b0, 33};
        vecs[9] = '{32'h0000_0007, 16'h0000, 32'hFFFF_FFFF, 16'h0007, 1'b1, 1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", {16'b0, remainder}, 32'd0);
        chk("rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // backpressure: hold result in DONE, ignore new requests
        send(32'h0000_0064, 16'h0007);
        wait_valid(lat);
        chk("bp_latency", lat, 33);
        in_valid = 1'b1;
        dividend = 32'h0000_0100;
        divisor  = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_quotient", quotient, 32'h0000_000E);
            chk("bp_remainder", {16'b0, remainder}, 32'h0000_0002);
            chk("bp_div_by_zero", {31'b0, div_by_zero}, 32'd0);
        end
        in_valid = 1'b0;
        handoff();
        run_op(vecs[2]);

        // reset in the middle of RUN
        send(32'hFFFF_FFFF, 16'hFFFF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_quotient", quotient, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready_rel", {31'b0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_stale_valid", {31'b0, out_valid}, 32'd0);
        run_op(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
